// File: rtl/pucch_cyc_shift_seq_gen.sv
// PUCCH cyclic-shift sequence generator: Gold c-sequence with multi-bit stepping,
// fast-forward to slot/symbol, and a prefetching valid/ready output of n_cs and alpha index.
module pucch_cyc_shift_seq_gen #(
   parameter int ADV_BITS = 8,
   parameter int NC       = 1600,
   parameter int N_RB_SC  = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [2:0]  i_pucch_format,
   input  logic        i_ext_cp,
   input  logic [3:0]  i_m0,
   input  logic [3:0]  i_mcs,
   input  logic        i_interlace,
   input  logic [3:0]  i_nirb,
   input  logic [7:0]  i_nslot,
   input  logic [9:0]  i_nid,
   input  logic [15:0] i_rnti,
   input  logic [3:0]  i_start_sym,
   input  logic [3:0]  i_nsym,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [7:0]  o_ncs,
   output logic [3:0]  o_alpha_idx,
   output logic [3:0]  o_sym,
   output logic        o_last,
   output logic        o_busy,
   output logic        o_err
);

   localparam int SHIFT = $clog2(ADV_BITS);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SKIP, S_GEN, S_OUT} state_t;
   state_t state, state_nx;

   logic [30:0] x1, x2, x1_nx, x2_nx, cinit_q, cinit_in;
   logic [19:0] skip_cnt, skip_bits, skip_k;
   logic [11:0] sym_pos;
   logic [6:0]  base_q, base_in;
   logic [5:0]  mint_in;
   logic [4:0]  nsymb_in;
   logic [3:0]  last_sym_q, sym_nx_q, gen_left;
   logic [2:0]  bit_idx;
   logic [7:0]  acc, acc_nx, src_ncs, pf_ncs;
   logic [ADV_BITS-1:0] bits;
   logic [8:0]  red;
   logic [3:0]  alpha_mod;
   logic        req_bad, accept, reject, step_en, gen_en, byte_done;
   logic        fire, out_free, load_out, pf_valid, pf_take, pf_valid_nx;

   // Request validation and configuration derived from the start-cycle inputs.
   always_comb begin
      nsymb_in  = i_ext_cp ? 5'd12 : 5'd14;
      req_bad   = (i_pucch_format > 3'd4) || (i_m0 > 4'd11) || (i_mcs > 4'd11) ||
                  (i_interlace && (i_nirb > 4'd9)) || (i_nsym == 4'd0) ||
                  (({1'b0, i_start_sym} + {1'b0, i_nsym}) > nsymb_in);
      accept    = (state == S_IDLE) && i_start && !req_bad;
      reject    = (state == S_IDLE) && i_start && req_bad;
      sym_pos   = 12'(nsymb_in) * 12'(i_nslot) + 12'(i_start_sym);
      skip_bits = 20'(NC) + {5'd0, sym_pos, 3'd0};
      skip_k    = skip_bits >> SHIFT;
      mint_in   = (i_interlace && (i_pucch_format <= 3'd1)) ? 6'(i_nirb) * 6'd5 : 6'd0;
      base_in   = 7'(i_m0) + 7'(i_mcs) + 7'(mint_in);
      cinit_in  = (i_pucch_format <= 3'd1) ? {21'd0, i_nid} : {i_rnti, 5'd0, i_nid};
   end

   // ADV_BITS LFSR steps per clock; bit j of 'bits' is the j-th c-sequence bit produced.
   always_comb begin
      x1_nx = x1;
      x2_nx = x2;
      bits  = '0;
      for (int j = 0; j < ADV_BITS; j++) begin
         bits[j] = x1_nx[0] ^ x2_nx[0];
         x1_nx   = {x1_nx[3] ^ x1_nx[0], x1_nx[30:1]};
         x2_nx   = {x2_nx[3] ^ x2_nx[2] ^ x2_nx[1] ^ x2_nx[0], x2_nx[30:1]};
      end
   end

   // Generator stalls only when both the output register and the prefetch slot are occupied.
   always_comb begin
      fire        = o_valid && i_ready;
      out_free    = !o_valid || fire;
      gen_en      = ((state == S_GEN) || (state == S_OUT)) && (gen_left != 4'd0) &&
                    (!pf_valid || out_free);
      step_en     = (state == S_SKIP) || gen_en;
      byte_done   = gen_en && (bit_idx == 3'(8 - ADV_BITS));
      acc_nx      = acc | (8'(bits) << bit_idx);
      load_out    = ((state == S_GEN) || (state == S_OUT)) && out_free && (pf_valid || byte_done);
      src_ncs     = pf_valid ? pf_ncs : acc_nx;
      pf_take     = byte_done && !(load_out && !pf_valid);
      pf_valid_nx = (pf_valid && !load_out) || pf_take;
   end

   // Modulo reduction by conditional subtraction of N_RB_SC*2^k; the sum never reaches 32*N_RB_SC.
   always_comb begin
      red = 9'(base_q) + 9'(src_ncs);
      for (int k = 4; k >= 0; k--) begin
         if (red >= 9'(N_RB_SC << k)) red = red - 9'(N_RB_SC << k);
      end
      alpha_mod = 4'(red);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_LOAD;
         S_LOAD:  state_nx = (skip_cnt == 20'd0) ? S_GEN : S_SKIP;
         S_SKIP:  if (skip_cnt == 20'd1) state_nx = S_GEN;
         S_GEN:   if (load_out) state_nx = S_OUT;
         S_OUT:   if (fire && o_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   assign o_busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x1          <= '0;
         x2          <= '0;
         cinit_q     <= '0;
         skip_cnt    <= '0;
         base_q      <= '0;
         last_sym_q  <= '0;
         sym_nx_q    <= '0;
         gen_left    <= '0;
         bit_idx     <= '0;
         acc         <= '0;
         pf_valid    <= 1'b0;
         pf_ncs      <= '0;
         o_valid     <= 1'b0;
         o_ncs       <= '0;
         o_alpha_idx <= '0;
         o_sym       <= '0;
         o_last      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_err <= reject;
         if (accept) begin
            cinit_q    <= cinit_in;
            skip_cnt   <= skip_k;
            base_q     <= base_in;
            last_sym_q <= 4'(i_start_sym + i_nsym - 4'd1);
            sym_nx_q   <= i_start_sym;
            gen_left   <= i_nsym;
         end
         if (state == S_LOAD) begin
            x1      <= 31'd1;
            x2      <= cinit_q;
            bit_idx <= '0;
            acc     <= '0;
         end else if (step_en) begin
            x1 <= x1_nx;
            x2 <= x2_nx;
         end
         if (state == S_SKIP) skip_cnt <= skip_cnt - 20'd1;
         if (gen_en) begin
            bit_idx <= byte_done ? 3'd0 : bit_idx + 3'(ADV_BITS);
            acc     <= byte_done ? 8'd0 : acc_nx;
         end
         if (byte_done) gen_left <= gen_left - 4'd1;
         pf_valid <= pf_valid_nx;
         if (pf_take) pf_ncs <= acc_nx;
         if (load_out) begin
            o_valid     <= 1'b1;
            o_ncs       <= src_ncs;
            o_alpha_idx <= alpha_mod;
            o_sym       <= sym_nx_q;
            o_last      <= (sym_nx_q == last_sym_q);
            sym_nx_q    <= sym_nx_q + 4'd1;
         end else if (fire) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pucch_cyc_shift_seq_gen.sv
// Scoreboard bench for pucch_cyc_shift_seq_gen: directed runs push expected words,
// a negedge monitor pops and compares on every handshake.
module tb_pucch_cyc_shift_seq_gen;

   localparam int NC = 1600;

   logic        clk, rst, i_start, i_ext_cp, i_interlace, i_ready;
   logic [2:0]  i_pucch_format;
   logic [3:0]  i_m0, i_mcs, i_nirb, i_start_sym, i_nsym;
   logic [7:0]  i_nslot;
   logic [9:0]  i_nid;
   logic [15:0] i_rnti;
   logic        o_valid, o_last, o_busy, o_err;
   logic [7:0]  o_ncs;
   logic [3:0]  o_alpha_idx, o_sym;

   typedef struct packed {
      logic [7:0] ncs;
      logic [3:0] alpha;
      logic [3:0] sym;
      logic       last;
   } word_t;

   word_t exp_q[$];
   word_t held, cur;
   bit    hold_pending;
   int    n_vec, n_miss;
   bit    x1_arr[0:8191];
   bit    x2_arr[0:8191];
   bit    c_arr[0:4095];

   pucch_cyc_shift_seq_gen dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_pucch_format(i_pucch_format),
      .i_ext_cp(i_ext_cp), .i_m0(i_m0), .i_mcs(i_mcs), .i_interlace(i_interlace),
      .i_nirb(i_nirb), .i_nslot(i_nslot), .i_nid(i_nid), .i_rnti(i_rnti),
      .i_start_sym(i_start_sym), .i_nsym(i_nsym), .i_ready(i_ready),
      .o_valid(o_valid), .o_ncs(o_ncs), .o_alpha_idx(o_alpha_idx), .o_sym(o_sym),
      .o_last(o_last), .o_busy(o_busy), .o_err(o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not terminate");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input int actual, input int required);
      n_vec++;
      if (actual != required) begin
         n_miss++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
      end
   endtask

   // Golden Gold sequence built from the defining recursions, c(n) = x1(n+Nc) ^ x2(n+Nc).
   task automatic build_seq(input logic [30:0] cinit, input int nbits);
      for (int i = 0; i < 31; i++) begin
         x1_arr[i] = (i == 0);
         x2_arr[i] = cinit[i];
      end
      for (int n = 0; n + 31 < NC + nbits; n++) begin
         x1_arr[n+31] = x1_arr[n+3] ^ x1_arr[n];
         x2_arr[n+31] = x2_arr[n+3] ^ x2_arr[n+2] ^ x2_arr[n+1] ^ x2_arr[n];
      end
      for (int n = 0; n < nbits; n++) c_arr[n] = x1_arr[n+NC] ^ x2_arr[n+NC];
   endtask

   function automatic logic [7:0] model_byte(input int b);
      logic [7:0] v = 8'd0;
      for (int m = 0; m < 8; m++) v[m] = c_arr[8*b+m];
      return v;
   endfunction

   task automatic apply_stimulus(input int fmt, input int ext, input int m0, input int mcs,
                                 input int il, input int nirb, input int nslot, input int nid,
                                 input int rnti, input int ss, input int nsym, input bit push);
      int     nsymb, base;
      longint cinit;
      word_t  w;
      if (push) begin
         nsymb = ext ? 12 : 14;
         base  = m0 + mcs + ((il != 0 && fmt <= 1) ? 5 * nirb : 0);
         cinit = (fmt <= 1) ? longint'(nid) : (longint'(rnti) * 32768 + nid);
         build_seq(cinit[30:0], 8 * (nsymb * nslot + ss + nsym));
         for (int k = 0; k < nsym; k++) begin
            w.ncs   = model_byte(nsymb * nslot + ss + k);
            w.alpha = 4'((base + w.ncs) % 12);
            w.sym   = 4'(ss + k);
            w.last  = (k == nsym - 1);
            exp_q.push_back(w);
         end
      end
      @(posedge clk); #1;
      i_pucch_format = 3'(fmt); i_ext_cp = ext[0]; i_m0 = 4'(m0); i_mcs = 4'(mcs);
      i_interlace = il[0]; i_nirb = 4'(nirb); i_nslot = 8'(nslot); i_nid = 10'(nid);
      i_rnti = 16'(rnti); i_start_sym = 4'(ss); i_nsym = 4'(nsym);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int lat);
      int cnt = 0;
      while (!o_valid && cnt < 5000) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_output(name, cnt, lat);
   endtask

   task automatic wait_idle(input string name);
      int cnt = 0;
      while (o_busy && cnt < 5000) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_output(name, int'(o_busy), 0);
   endtask

   task automatic check_err(input string name, input int fmt, input int m0, input int mcs,
                            input int il, input int nirb, input int ss, input int nsym);
      apply_stimulus(fmt, 0, m0, mcs, il, nirb, 0, 0, 0, ss, nsym, 1'b0);
      check_output({name, "_err"}, int'(o_err), 1);
      check_output({name, "_busy"}, int'(o_busy), 0);
      @(posedge clk); #1;
      check_output({name, "_pulse"}, int'(o_err), 0);
   endtask

   // Monitor: compares every handshake against the queue and checks stability under stall.
   always @(negedge clk) begin
      cur = '{ncs: o_ncs, alpha: o_alpha_idx, sym: o_sym, last: o_last};
      if (!rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) check_output("stall_stable", int'({o_valid, cur}), int'({1'b1, held}));
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) check_output("extra_word", int'(cur), -1);
            else check_output("word", int'(cur), int'(exp_q.pop_front()));
         end
         hold_pending = o_valid && !i_ready;
         held = cur;
      end
   end

   initial begin
      int streak;
      int pat[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      n_vec = 0; n_miss = 0; hold_pending = 1'b0;
      rst = 1'b0; i_start = 1'b0; i_ready = 1'b1;
      i_pucch_format = '0; i_ext_cp = 1'b0; i_m0 = '0; i_mcs = '0; i_interlace = 1'b0;
      i_nirb = '0; i_nslot = '0; i_nid = '0; i_rnti = '0; i_start_sym = '0; i_nsym = '0;
      #23;
      check_output("reset_outputs",
                   int'({o_valid, o_ncs, o_alpha_idx, o_sym, o_last, o_busy, o_err}), 0);
      @(posedge clk); #1 rst = 1'b1;

      $display("[TB] full-slot stream, cinit=0");
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 1'b1);
      wait_valid("latency_202", 202);
      streak = 0;
      while (o_valid && streak < 30) begin
         streak++;
         @(posedge clk); #1;
      end
      check_output("stream_len", streak, 14);
      check_output("busy_drop", int'(o_busy), 0);

      $display("[TB] slot offset, extended CP");
      apply_stimulus(1, 1, 3, 4, 0, 0, 3, 517, 0, 2, 4, 1'b1);
      wait_valid("latency_240", 240);
      wait_idle("idle_slot");

      $display("[TB] alpha arithmetic");
      apply_stimulus(0, 0, 11, 11, 1, 9, 1, 123, 0, 0, 3, 1'b1);
      wait_valid("latency_216", 216);
      wait_idle("idle_alpha0");
      apply_stimulus(2, 0, 5, 3, 1, 9, 0, 77, 'h1234, 11, 3, 1'b1);
      wait_valid("latency_213", 213);
      wait_idle("idle_alpha2");

      $display("[TB] backpressure and start while busy");
      apply_stimulus(3, 0, 2, 9, 0, 0, 2, 1000, 'hBEEF, 1, 6, 1'b1);
      wait_valid("latency_231", 231);
      for (int k = 0; k < 12; k++) begin
         i_ready = pat[k][0];
         if (k == 4) begin
            i_start = 1'b1;
            i_m0 = 4'd12;
         end
         @(posedge clk); #1;
         if (k == 4) begin
            i_start = 1'b0;
            check_output("busy_start_err", int'(o_err), 0);
            check_output("busy_start_busy", int'(o_busy), 1);
         end
      end
      i_ready = 1'b1;
      wait_idle("idle_bp");

      $display("[TB] rejected requests");
      check_err("nsym0", 0, 0, 0, 0, 0, 0, 0);
      check_err("overrun", 0, 0, 0, 0, 0, 10, 5);
      check_err("fmt5", 5, 0, 0, 0, 0, 0, 4);
      check_err("m0_12", 0, 12, 0, 0, 0, 0, 4);
      check_err("mcs_12", 1, 0, 12, 0, 0, 0, 4);
      check_err("nirb_10", 0, 0, 0, 1, 10, 0, 4);

      $display("[TB] reset during skip");
      apply_stimulus(0, 0, 1, 1, 0, 0, 10, 9, 0, 0, 2, 1'b0);
      repeat (50) @(posedge clk);
      #1 check_output("busy_in_skip", int'(o_busy), 1);
      #3 rst = 1'b0;
      #1 check_output("reset_abort",
                      int'({o_valid, o_ncs, o_alpha_idx, o_sym, o_last, o_busy, o_err}), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      apply_stimulus(4, 0, 7, 6, 0, 0, 0, 300, 'h00A5, 0, 2, 1'b1);
      wait_valid("latency_after_reset", 202);
      wait_idle("idle_after_reset");

      repeat (4) @(posedge clk);
      #1 check_output("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/pucch_cyc_shift_seq_gen.md
Name: pucch_cyc_shift_seq_gen

Overview:
Parametrised successor to the PUCCH cyclic-shift alpha generator. It contains its own Gold (c-sequence) generator with multi-bit stepping and fast-forward to the slot and symbol position. It supports normal and extended CP, a start symbol, and interlaced mint. For each PUCCH symbol it emits n_cs and the alpha index (m0+mcs+mint+n_cs) mod 12 over a valid/ready stream, feeding the low-PAPR sequence rotator.

Parameters:
ADV_BITS, 8, c-sequence bits advanced per clock; legal values 1, 2, 4, 8.
NC, 1600, Gold sequence offset Nc.
N_RB_SC, 12, modulus of the cyclic shift.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request; all i_* configuration inputs are sampled on this cycle
i_pucch_format  in  3  PUCCH format 0-4
i_ext_cp  in  1  1: Nsymb=12, 0: Nsymb=14
i_m0  in  4  initial cyclic shift, 0-11
i_mcs  in  4  sequence cyclic shift, 0-11
i_interlace  in  1  interlaced mapping enable
i_nirb  in  4  RB index within interlace, 0-9
i_nslot  in  8  slot in frame, 0-159
i_nid  in  10  scrambling identity, 0-1023
i_rnti  in  16  RNTI
i_start_sym  in  4  first symbol l0
i_nsym  in  4  number of symbols, 1-14
i_ready  in  1  downstream ready
o_valid  out  1  output word valid
o_ncs  out  8  n_cs for this symbol
o_alpha_idx  out  4  alpha index, 0-11
o_sym  out  4  symbol index l
o_last  out  1  marks the final symbol
o_busy  out  1  high from accept until the last handshake
o_err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; o_valid, o_ncs, o_alpha_idx, o_sym, o_last, o_busy, o_err all 0; LFSRs cleared. Reset mid-operation aborts the run with no further output.
- Configuration is latched on i_start; later input changes have no effect until the next accepted start.
- Rejection: i_start in IDLE is rejected if any of these hold: format>4, m0>11, mcs>11, nirb>9 with interlace, nsym=0, or start_sym+nsym>Nsymb. On rejection o_err=1 for one cycle and the block stays IDLE.
- i_start while o_busy is ignored, with no o_err.
- cinit: formats 0/1 use nid; formats 2/3/4 use rnti*2^15+nid (31 bits).
- LFSRs: x1 is seeded to 1 followed by zeros; x2 is seeded to cinit. Each step produces c(n)=x1(n)^x2(n).
- mint is 5*nirb when interlace=1 and format is 0 or 1; otherwise mint is 0.
- FSM: IDLE -> LOAD (1 cycle, seed LFSRs) -> SKIP -> GEN -> OUT.
  - SKIP runs K=(NC+8*(Nsymb*nslot+start_sym))/ADV_BITS cycles, stepping ADV_BITS bits per cycle and discarding them.
  - GEN runs 8/ADV_BITS cycles and assembles n_cs = sum over m=0..7 of 2^m*c(...+m). The first bit is the LSB.
  - OUT holds o_valid.
- First o_valid: asserted 1+K+8/ADV_BITS cycles after the i_start edge.
- Prefetch buffer: while a word is held in OUT, GEN prefetches the next symbol's byte into a one-entry buffer. With ADV_BITS=8 and i_ready=1, o_valid stays high for nsym consecutive cycles.
- Handshake: a transfer occurs when o_valid and i_ready are both high. Outputs stay stable while o_valid=1 and i_ready=0.
- o_sym starts at start_sym and increments by one per transfer.
- o_last=1 on the word with o_sym=start_sym+nsym-1. After the last transfer, o_valid and o_busy drop on the next cycle and the FSM returns to IDLE.
- Arithmetic: the sum m0+mcs+mint+ncs is 9 bits (max 11+11+45+255=322). o_alpha_idx = sum mod 12 via subtract-compare or constant-reciprocal; no divider.
- i_start coincident with the final handshake is ignored, because busy is still high.

Test Plan:
- Reset: rst low mid-SKIP with o_busy=1 -> all outputs 0 immediately; after release, a new i_start works.
- Latency: ADV_BITS=8, normal CP, nslot=0, start_sym=0, nsym=14, i_ready=1 -> o_valid rises 202 cycles after i_start; 14 consecutive valids; o_sym 0..13; o_last on 13. Every o_ncs matches the golden c-sequence model for cinit=nid=0.
- Slot offset: nslot=3, ext_cp=1, start_sym=2, nsym=4 -> first valid after 1+200+38+1=240 cycles; o_sym 2..5; o_ncs equals model bytes 38..41 after the Nc offset.
- Alpha math: format 0, m0=11, mcs=11, interlace=1, nirb=9 -> o_alpha_idx=(67+o_ncs) mod 12 for every word; formats 2-4 ignore interlace.
- Backpressure: i_ready toggling 1010 and held low 5 cycles -> outputs stable while stalled; no duplicated or lost symbols.
- Errors: nsym=0; start_sym=10 with nsym=5 and normal CP; format=5; m0=12 -> one-cycle o_err each, o_busy stays 0. i_start during busy -> no effect.
